uart_tx_arbiter: RTL and testbench

- Controller in front of the UART transmitter's memory-mapped write port.
- Shares the transmit queue between two byte requesters (CPU, trace/debug source) using round-robin arbitration, and drives the chip-select, read/write and address strobes.
- Owns the 13-bit baud divisor (DBH/DBL). Divisor changes are held in a shadow register and applied only when the transmitter is fully idle, so no frame is ever sent with a mixed baud rate.

---
 rtl/uart_tx_arbiter.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter between two byte requesters in front of
// the UART transmit queue write port, plus the shadowed 13-bit baud divisor.
// Divisor changes are applied only once the queue is empty and the last frame
// has finished, so a frame never goes out with a mixed baud rate.
// Optional build macro: UART_TX_ARB_STATS_EN adds per-requester byte counters.
module uart_tx_arbiter #(
    parameter logic [12:0] DIV_RESET  = 13'h01B2,
    parameter int          GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  data0,
    input  logic [7:0]  data1,
    output logic        ack0,
    output logic        ack1,
    input  logic        cfg_we,
    input  logic        cfg_sel,
    input  logic [7:0]  cfg_data,
    output logic        cfg_pending,
    input  logic        tx_queue_full,
    input  logic [3:0]  tx_num_remaining,
    input  logic        tx_done,
`ifdef UART_TX_ARB_STATS_EN
    input  logic        stats_clr,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1,
`endif
    output logic        iocs_n,
    output logic        iorw_n,
    output logic [1:0]  ioaddr,
    output logic [7:0]  databus,
    output logic [7:0]  DBL,
    output logic [4:0]  DBH
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        sent_q, sent_d;
    logic [1:0]  gap_cnt_q, gap_cnt_d;
    logic [12:0] shadow_q, shadow_d;
    logic [12:0] div_q, div_d;
    logic        pending_q, pending_d;
    logic        iocs_n_q, iocs_n_d;
    logic        iorw_n_q, iorw_n_d;
    logic [7:0]  databus_q, databus_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        winner;

    // Next-state and registered-output decode; shadow writes take priority over the clear on apply
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sent_d       = sent_q;
        gap_cnt_d    = gap_cnt_q;
        shadow_d     = shadow_q;
        div_d        = div_q;
        pending_d    = pending_q;
        iocs_n_d     = 1'b1;
        iorw_n_d     = 1'b1;
        databus_d    = databus_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        winner       = (req0 && req1) ? ~last_grant_q : req1;

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    if ((tx_num_remaining == 4'd8) && (tx_done || !sent_q)) begin
                        div_d     = shadow_q;
                        pending_d = 1'b0;
                    end
                end else if ((req0 || req1) && !tx_queue_full) begin
                    last_grant_d = winner;
                    state_d      = ST_WRITE;
                    iocs_n_d     = 1'b0;
                    iorw_n_d     = 1'b0;
                    databus_d    = winner ? data1 : data0;
                    ack0_d       = ~winner;
                    ack1_d       = winner;
                end
            end
            ST_WRITE: begin
                sent_d    = 1'b1;
                gap_cnt_d = 2'(GAP_CYCLES - 1);
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == 2'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cfg_we) begin
            if (cfg_sel) begin
                shadow_d[12:8] = cfg_data[4:0];
            end else begin
                shadow_d[7:0] = cfg_data;
            end
            pending_d = 1'b1;
        end
    end

    // State and output registers; reset drops the strobe and acks at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            sent_q       <= 1'b0;
            gap_cnt_q    <= 2'd0;
            shadow_q     <= DIV_RESET;
            div_q        <= DIV_RESET;
            pending_q    <= 1'b0;
            iocs_n_q     <= 1'b1;
            iorw_n_q     <= 1'b1;
            databus_q    <= 8'h00;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sent_q       <= sent_d;
            gap_cnt_q    <= gap_cnt_d;
            shadow_q     <= shadow_d;
            div_q        <= div_d;
            pending_q    <= pending_d;
            iocs_n_q     <= iocs_n_d;
            iorw_n_q     <= iorw_n_d;
            databus_q    <= databus_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
        end
    end

`ifdef UART_TX_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    // Saturating byte counters; a clear wins over an ack in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= 16'h0000;
            cnt1_q <= 16'h0000;
        end else if (stats_clr) begin
            cnt0_q <= 16'h0000;
            cnt1_q <= 16'h0000;
        end else begin
            if (ack0_q && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
            if (ack1_q && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign cfg_pending = pending_q;
    assign iocs_n      = iocs_n_q;
    assign iorw_n      = iorw_n_q;
    assign ioaddr      = 2'b00;
    assign databus     = databus_q;
    assign DBL         = div_q[7:0];
    assign DBH         = div_q[12:8];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized requester
// traffic, all checked every cycle against a transaction-level reference model.
module tb_uart_tx_arbiter;

    localparam logic [12:0] DIV_RST = 13'h01B2;
    localparam int          GAP     = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [7:0]  data0, data1;
    logic        ack0, ack1;
    logic        cfg_we, cfg_sel;
    logic [7:0]  cfg_data;
    logic        cfg_pending;
    logic        tx_queue_full;
    logic [3:0]  tx_num_remaining;
    logic        tx_done;
    logic        iocs_n, iorw_n;
    logic [1:0]  ioaddr;
    logic [7:0]  databus;
    logic [7:0]  DBL;
    logic [4:0]  DBH;
`ifdef UART_TX_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] cnt0, cnt1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.DIV_RESET(DIV_RST), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .ack0(ack0), .ack1(ack1),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .cfg_pending(cfg_pending),
        .tx_queue_full(tx_queue_full), .tx_num_remaining(tx_num_remaining),
        .tx_done(tx_done),
`ifdef UART_TX_ARB_STATS_EN
        .stats_clr(stats_clr), .cnt0(cnt0), .cnt1(cnt1),
`endif
        .iocs_n(iocs_n), .iorw_n(iorw_n), .ioaddr(ioaddr),
        .databus(databus), .DBL(DBL), .DBH(DBH)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The arbiter is free to grant once more than GAP cycles have passed since
    // the last write; grants alternate on ties; the divisor follows shadow rules.
    logic [12:0] m_shadow, m_div;
    bit          m_pending, m_sent, m_last, prev_rst;
    int          m_since;
    bit          p_r0, p_r1, p_full, p_done, p_we, p_sel;
    logic [7:0]  p_d0, p_d1, p_cd;
    logic [3:0]  p_num;

    always @(negedge clk) begin
        bit grant, apply, win;
        grant = 0; apply = 0; win = 0;
        if (!rst_n) begin
            m_shadow = DIV_RST; m_div = DIV_RST; m_pending = 0; m_sent = 0;
            m_last = 1; m_since = 1000; prev_rst = 1;
            check_eq("rst_iocs_n", iocs_n, 1);
            check_eq("rst_acks", {ack1, ack0}, 0);
            check_eq("rst_div", {DBH, DBL}, DIV_RST);
            check_eq("rst_pending", cfg_pending, 0);
        end else begin
            if (!prev_rst) begin
                grant = (m_since > GAP) && !m_pending && (p_r0 || p_r1) && !p_full;
                apply = (m_since > GAP) && m_pending && (p_num == 4'd8) && (p_done || !m_sent);
                win   = (p_r0 && p_r1) ? !m_last : p_r1;
                if (grant) begin
                    m_last = win; m_since = 0; m_sent = 1;
                end else if (m_since < 1000) begin
                    m_since++;
                end
                if (apply) begin
                    m_div = m_shadow; m_pending = 0;
                end
                if (p_we) begin
                    if (p_sel) m_shadow[12:8] = p_cd[4:0];
                    else       m_shadow[7:0]  = p_cd;
                    m_pending = 1;
                end
            end
            prev_rst = 0;
            check_eq("m_iocs_n", iocs_n, !grant);
            check_eq("m_iorw_n", iorw_n, !grant);
            check_eq("m_ioaddr", ioaddr, 0);
            check_eq("m_acks", {ack1, ack0}, grant ? (win ? 2'b10 : 2'b01) : 2'b00);
            if (grant) check_eq("m_databus", databus, win ? p_d1 : p_d0);
            check_eq("m_div", {DBH, DBL}, m_div);
            check_eq("m_pending", cfg_pending, m_pending);
        end
        p_r0 = req0; p_r1 = req1; p_d0 = data0; p_d1 = data1;
        p_full = tx_queue_full; p_num = tx_num_remaining; p_done = tx_done;
        p_we = cfg_we; p_sel = cfg_sel; p_cd = cfg_data;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int who, output bit seen);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if ((who == 0) ? ack0 : ack1) begin
                seen = 1;
                return;
            end
        end
        check_eq("ack_timeout", 0, 1);
    endtask

    task automatic wait_write(output bit seen);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!iocs_n) begin
                seen = 1;
                return;
            end
        end
        check_eq("write_timeout", 0, 1);
    endtask

    initial begin
        bit   seen;
        int   prev_w;
        logic [7:0] exp_b;

        rst_n = 0; req0 = 0; req1 = 0; data0 = 0; data1 = 0;
        cfg_we = 0; cfg_sel = 0; cfg_data = 0;
        tx_queue_full = 0; tx_num_remaining = 4'd8; tx_done = 0;
`ifdef UART_TX_ARB_STATS_EN
        stats_clr = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_iorw_n", iorw_n, 1);
        check_eq("reset_databus", databus, 0);
        rst_n = 1;
        tick();

        // single request
        req0 = 1; data0 = 8'hA5;
        tick();
        check_eq("single_iocs_n", iocs_n, 0);
        check_eq("single_iorw_n", iorw_n, 0);
        check_eq("single_databus", databus, 8'hA5);
        check_eq("single_ack0", ack0, 1);
        req0 = 0;
        tick();
        check_eq("single_gap_iocs_n", iocs_n, 1);
        tick();

        // full queue holds requester 1 off
        req1 = 1; data1 = 8'h77; tx_queue_full = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("full_iocs_n", iocs_n, 1);
            check_eq("full_ack1", ack1, 0);
        end
        tx_queue_full = 0;
        tick();
        check_eq("unfull_iocs_n", iocs_n, 0);
        check_eq("unfull_ack1", ack1, 1);
        check_eq("unfull_databus", databus, 8'h77);
        req1 = 0;
        repeat (2) tick();

        // divisor update while queue not drained
        tx_num_remaining = 4'd6; tx_done = 0;
        cfg_we = 1; cfg_sel = 0; cfg_data = 8'h2C;
        tick();
        cfg_sel = 1; cfg_data = 8'h0A;
        tick();
        cfg_we = 0; req0 = 1; data0 = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("div_pending", cfg_pending, 1);
            check_eq("div_hold", {DBH, DBL}, 13'h01B2);
            check_eq("div_nogrant", iocs_n, 1);
        end
        tx_num_remaining = 4'd8; tx_done = 1;
        tick();
        check_eq("div_applied", {DBH, DBL}, 13'h0A2C);
        check_eq("div_pending_clr", cfg_pending, 0);
        wait_ack(0, seen);
        req0 = 0; tx_done = 0;
        repeat (2) tick();

        // reset during a write
        req0 = 1; data0 = 8'h5A;
        wait_ack(0, seen);
        rst_n = 0;
        #1;
        check_eq("midrst_iocs_n", iocs_n, 1);
        check_eq("midrst_ack0", ack0, 0);
        check_eq("midrst_div", {DBH, DBL}, 13'h01B2);
        req0 = 0;
        repeat (2) tick();
        rst_n = 1;

        // contention: req0 wins first tie after reset, then strict alternation
        req0 = 1; req1 = 1; data0 = 8'h11; data1 = 8'h22;
        prev_w = -1;
        for (int k = 0; k < 6; k++) begin
            wait_write(seen);
            exp_b = (k % 2 == 0) ? 8'h11 : 8'h22;
            check_eq("rr_databus", databus, exp_b);
            check_eq("rr_alternate", (ack1 ? 1 : 0) != prev_w, 1);
            prev_w = ack1 ? 1 : 0;
        end
        req0 = 0; req1 = 0;
        repeat (3) tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (ack0) req0 = 0;
            else if (!req0 && ($urandom % 4 == 0)) begin req0 = 1; data0 = 8'($urandom); end
            else if (req0 && ($urandom % 64 == 0)) req0 = 0;
            if (ack1) req1 = 0;
            else if (!req1 && ($urandom % 4 == 0)) begin req1 = 1; data1 = 8'($urandom); end
            else if (req1 && ($urandom % 64 == 0)) req1 = 0;
            tx_queue_full    = ($urandom % 5 == 0);
            tx_num_remaining = ($urandom % 3 == 0) ? 4'd8 : 4'($urandom_range(0, 7));
            tx_done          = $urandom % 2;
            cfg_we           = ($urandom % 16 == 0);
            cfg_sel          = $urandom % 2;
            cfg_data         = 8'($urandom);
        end
        req0 = 0; req1 = 0; cfg_we = 0; tx_queue_full = 0;
        tx_num_remaining = 4'd8; tx_done = 1;
        repeat (4) tick();

`ifdef UART_TX_ARB_STATS_EN
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            req0 = 1; data0 = 8'(k);
            wait_ack(0, seen);
            req0 = 0;
            tick();
        end
        req0 = 1;
        wait_ack(0, seen);
        check_eq("stats_cnt0_pre", cnt0, 3);
        stats_clr = 1; req0 = 0;
        tick();
        stats_clr = 0;
        check_eq("stats_cnt0_clr", cnt0, 0);
        check_eq("stats_cnt1", cnt1, 0);
        repeat (2) tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
